// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO feeding a serializer with configurable data
// bits, parity and stop bits. Back-to-back frames are sent with no idle gap.
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [DATA_BITS-1:0]               data,
    input  logic                               valid,
    output logic                               ready,
    output logic                               tx,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned BIT_W        = $clog2(DATA_BITS);
    localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT * STOP_BITS);
    localparam bit          HAS_PARITY   = (PARITY != 0);
    localparam bit          ODD_PARITY   = (PARITY == 1);

    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(CLKS_PER_BIT * STOP_BITS - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_ready;

    state_t               r_state;
    logic [BAUD_W-1:0]    r_baud;
    logic [BIT_W-1:0]     r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_xor;
    logic                 r_tx;
    logic                 r_busy;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_stop_end;
    logic [CNT_W-1:0]     w_count_nxt;
    logic                 w_tx_nxt;
    logic [DATA_BITS-1:0] w_head;

    assign w_push     = valid && r_ready;
    assign w_bit_end  = (r_baud == BIT_LAST);
    assign w_stop_end = (r_baud == STOP_LAST);
    assign w_head     = r_mem[r_rd_ptr];

    // The serializer takes a new entry from IDLE, or on the last stop cycle for a gapless stream.
    assign w_pop = (r_count != '0) &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_stop_end));

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; the count carries occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != CNT_FULL);
        end
    end

    always_comb begin
        w_tx_nxt = 1'b1;
        case (r_state)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = r_shift[0];
            S_PARITY: w_tx_nxt = ODD_PARITY ? ~r_xor : r_xor;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_xor   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_tx <= w_tx_nxt;
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    r_bit  <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_xor   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        r_xor   <= r_xor ^ r_shift[0];
                        if (r_bit == DATA_LAST) begin
                            r_bit   <= '0;
                            r_state <= HAS_PARITY ? S_PARITY : S_STOP;
                        end else begin
                            r_bit <= r_bit + BIT_W'(1);
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_state <= S_STOP;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_stop_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_xor   <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready      = r_ready;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: four differently configured instances, one
// line monitor that decodes the selected tx line and compares against queued frames.
module tb_uart_tx_fifo;

    localparam int CPB = 10;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         start;
        int         len;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic [3:0] valid_v = 4'b0000;
    logic [1:0] sel = 2'd0;
    int         cyc = 0;

    logic       rdy_a, rdy_b, rdy_c, rdy_d;
    logic       tx_a, tx_b, tx_c, tx_d;
    logic       busy_a, busy_b, busy_c, busy_d;
    logic [4:0] cnt_a, cnt_b, cnt_c;
    logic [2:0] cnt_d;
    logic       w_line;

    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];

    int cfg_db  [4] = '{8, 8, 7, 8};
    int cfg_par [4] = '{0, 1, 1, 0};
    int cfg_stop[4] = '{1, 1, 2, 1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) u_a (
        .clk(clk), .rst_n(rst_n), .data(data), .valid(valid_v[0]), .ready(rdy_a),
        .tx(tx_a), .busy(busy_a), .fifo_count(cnt_a));

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) u_b (
        .clk(clk), .rst_n(rst_n), .data(data), .valid(valid_v[1]), .ready(rdy_b),
        .tx(tx_b), .busy(busy_b), .fifo_count(cnt_b));

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(1),
                   .STOP_BITS(2), .FIFO_DEPTH(16)) u_c (
        .clk(clk), .rst_n(rst_n), .data(data[6:0]), .valid(valid_v[2]), .ready(rdy_c),
        .tx(tx_c), .busy(busy_c), .fifo_count(cnt_c));

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_d (
        .clk(clk), .rst_n(rst_n), .data(data), .valid(valid_v[3]), .ready(rdy_d),
        .tx(tx_d), .busy(busy_d), .fifo_count(cnt_d));

    always_comb begin
        case (sel)
            2'd0:    w_line = tx_a;
            2'd1:    w_line = tx_b;
            2'd2:    w_line = tx_c;
            default: w_line = tx_d;
        endcase
    end

    task automatic check(input string name, input logic ok, input int act, input int req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    function automatic logic ready_of(input int s);
        case (s)
            0:       return rdy_a;
            1:       return rdy_b;
            2:       return rdy_c;
            default: return rdy_d;
        endcase
    endfunction

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Present a byte at a negedge; returns the cycle index of the accepting edge.
    task automatic send(input int s, input logic [7:0] d, output int acc);
        int n;
        n = 0;
        data = d;
        valid_v[s] = 1'b1;
        while (!ready_of(s) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("send_timeout", 1'b0, n, 1000);
        acc = cyc + 1;
        @(negedge clk);
        valid_v[s] = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic p, input int st, input int len);
        exp_t e;
        e.data = d; e.par = p; e.start = st; e.len = len;
        exp_q.push_back(e);
    endtask

    // Line monitor: on each falling edge pop the next expected frame and compare every sample.
    initial begin : monitor
        logic prev, smp;
        logic bits [0:15];
        int   nb, n, mism, s0;
        exp_t e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            smp = w_line;
            if (rst_n && prev && !smp) begin
                s0 = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", exp_q.size() != 0, s0, -1);
                end else begin
                    e = exp_q.pop_front();
                    if (e.start >= 0) check("frame_start", s0 == e.start, s0, e.start);
                    nb = 0;
                    bits[nb++] = 1'b0;
                    for (int i = 0; i < cfg_db[sel]; i++) bits[nb++] = e.data[i];
                    if (cfg_par[sel] != 0) bits[nb++] = e.par;
                    for (int i = 0; i < cfg_stop[sel]; i++) bits[nb++] = 1'b1;
                    n = (e.len > 0) ? e.len : nb * CPB;
                    mism = 0;
                    for (int j = 0; j < n; j++) begin
                        if (j > 0) begin
                            @(negedge clk);
                            smp = w_line;
                        end
                        if (smp !== bits[j / CPB]) mism++;
                    end
                    check($sformatf("frame_wave_%02h", e.data), mism == 0, mism, 0);
                end
            end
            prev = smp;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int a0, a1, s0;
        int acc4 [6];
        logic [7:0] b4 [6];
        b4 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx", tx_a == 1'b1, tx_a, 1);
        check("rst_ready", rdy_a == 1'b1, rdy_a, 1);
        check("rst_busy", busy_a == 1'b0, busy_a, 0);
        check("rst_count", cnt_a == 5'd0, cnt_a, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1 single byte 0x55, 100-cycle frame
        sel = 2'd0;
        send(0, 8'h55, a0);
        expect_frame(8'h55, 1'b0, a0 + 2, 0);
        check("t1_busy_before_pop", busy_a == 1'b0, busy_a, 0);
        check("t1_count_queued", cnt_a == 5'd1, cnt_a, 1);
        @(negedge clk);
        check("t1_busy_at_pop", busy_a == 1'b1, busy_a, 1);
        check("t1_count_popped", cnt_a == 5'd0, cnt_a, 0);
        wait_cyc(a0 + 100);
        check("t1_busy_last_stop", busy_a == 1'b1, busy_a, 1);
        @(negedge clk);
        check("t1_busy_dropped", busy_a == 1'b0, busy_a, 0);
        wait_cyc(a0 + 110);

        // Even parity, 0x07 then 0x03 back to back
        sel = 2'd1;
        send(1, 8'h07, a0);
        expect_frame(8'h07, 1'b1, a0 + 2, 0);
        send(1, 8'h03, a1);
        expect_frame(8'h03, 1'b0, a0 + 2 + 110, 0);
        check("t2_second_accept", a1 == a0 + 1, a1, a0 + 1);
        wait_cyc(a0 + 2 + 220 + 5);

        // 7 data bits, odd parity, 2 stop bits, 0x00
        sel = 2'd2;
        send(2, 8'h00, a0);
        expect_frame(8'h00, 1'b1, a0 + 2, 0);
        wait_cyc(a0 + 2 + 110 + 5);

        // Depth 4, valid held for 6 bytes
        sel = 2'd3;
        for (int k = 0; k < 6; k++) begin
            send(3, b4[k], acc4[k]);
            expect_frame(b4[k], 1'b0, acc4[0] + 2 + 100 * k, 0);
            if (k == 4) begin
                check("t4_ready_full", rdy_d == 1'b0, rdy_d, 0);
                check("t4_count_full", cnt_d == 3'd4, cnt_d, 4);
            end
        end
        a0 = acc4[0];
        check("t4_burst_accept", acc4[4] == a0 + 4, acc4[4], a0 + 4);
        check("t4_refill_accept", acc4[5] == a0 + 102, acc4[5], a0 + 102);

        // Full with concurrent pop: push rejected, count drops by one
        wait_cyc(a0 + 200);
        check("t6_full_ready", rdy_d == 1'b0, rdy_d, 0);
        data = 8'hAA;
        valid_v[3] = 1'b1;
        @(negedge clk);
        valid_v[3] = 1'b0;
        check("t6_reject_count", cnt_d == 3'd3, cnt_d, 3);

        // Count DEPTH-1 with concurrent pop: push accepted, count unchanged
        wait_cyc(a0 + 300);
        check("t6_pre_count", cnt_d == 3'd3, cnt_d, 3);
        data = 8'h77;
        valid_v[3] = 1'b1;
        check("t6_ready_room", rdy_d == 1'b1, rdy_d, 1);
        @(negedge clk);
        valid_v[3] = 1'b0;
        expect_frame(8'h77, 1'b0, a0 + 2 + 600, 0);
        check("t6_pushpop_count", cnt_d == 3'd3, cnt_d, 3);
        wait_cyc(a0 + 2 + 700 + 5);
        check("t6_drained_count", cnt_d == 3'd0, cnt_d, 0);

        // Mid-frame reset at cycle 35 of a 0x00 frame; queued bytes discarded
        sel = 2'd0;
        send(0, 8'h00, a0);
        expect_frame(8'h00, 1'b0, a0 + 2, 35);
        send(0, 8'h11, a1);
        send(0, 8'h22, a1);
        s0 = a0 + 2;
        wait_cyc(s0 + 34);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_tx_async_high", tx_a == 1'b1, tx_a, 1);
        check("t5_count_flushed", cnt_a == 5'd0, cnt_a, 0);
        check("t5_ready", rdy_a == 1'b1, rdy_a, 1);
        check("t5_busy", busy_a == 1'b0, busy_a, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        send(0, 8'hA5, a0);
        expect_frame(8'hA5, 1'b0, a0 + 2, 0);
        wait_cyc(a0 + 110);

        check("sb_drained", exp_q.size() == 0, exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
